// File: rtl/prio_enc_pkg.sv
// Shared definitions for the parametrised priority / round-robin encoder.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Round-robin successor of a winning index, wrapping at n (n need not be a power of two).
  function automatic int unsigned rot_next(input int unsigned idx, input int unsigned n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/prio_encoder_rr_find_first_set.sv
// Combinational search: first set bit of vec at or above start, wrapping modulo N.
module find_first_set #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx_c,
  output logic         found_c
);

  logic [N-1:0] win;
  int           pos;

  // Rotate so that bit 0 of win corresponds to position start.
  assign win = N'({vec, vec} >> start);

  always_comb begin
    idx_c   = '0;
    found_c = 1'b0;
    pos     = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (win[k]) begin
        pos = int'(start) + k;
        if (pos >= int'(N)) pos = pos - int'(N);
        idx_c   = W'(pos);
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) encoder with fixed-priority or round-robin selection over valid/ready.
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         none,
  output logic         multi,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] ptr;
  logic [N-1:0] rev;
  logic [N-1:0] ffs_vec;
  logic [W-1:0] ffs_start;
  logic [W-1:0] ffs_idx;
  logic         found;
  logic [W-1:0] sel_c;
  logic         multi_c;
  logic         accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Fixed priority is a search from the top: reverse the vector and scan from 0.
  always_comb begin
    rev = '0;
    for (int i = 0; i < int'(N); i++) rev[i] = req[int'(N) - 1 - i];
  end

  assign ffs_vec   = (mode == MODE_RR) ? req : rev;
  assign ffs_start = (mode == MODE_RR) ? ptr : '0;

  find_first_set #(.N(N), .W(W)) u_ffs (
    .vec    (ffs_vec),
    .start  (ffs_start),
    .idx_c  (ffs_idx),
    .found_c(found)
  );

  assign sel_c = !found            ? '0 :
                 (mode == MODE_RR) ? ffs_idx :
                                     W'(N - 1 - 32'(ffs_idx));

  assign multi_c = (req & (req - 1'b1)) != '0;

  // Output register, handshake state and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      none      <= 1'b0;
      multi     <= 1'b0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        idx       <= sel_c;
        none      <= !found;
        multi     <= multi_c;
        if (mode == MODE_RR && found) ptr <= W'(rot_next(32'(sel_c), N));
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised registered N-to-log2(N) encoder, the successor to the team's fixed 8-to-3 one-hot encoder. It accepts an arbitrary request vector, with any number of bits set, over a valid/ready handshake. It selects one index under either fixed-priority or round-robin policy and returns the result one cycle later with status flags. It sits between request collectors (interrupt lines, channel-busy vectors) and downstream dispatch logic that consumes one index per transfer.

## Interface
Parameters:
- N, default 8: request vector width; legal range 2..64.
- W, default $clog2(N): index width; derived, not overridden.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request vector; any bits may be set.
- in_valid  in  1  req is valid this cycle.
- in_ready  out  1  block can accept req this cycle.
- mode  in  1  0 = fixed priority (highest index wins); 1 = round-robin. Sampled with req.
- idx  out  W  encoded winning index.
- none  out  1  accepted req was all-zero.
- multi  out  1  accepted req had two or more bits set.
- out_valid  out  1  idx/none/multi valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- Accept occurs when in_valid && in_ready.
- in_ready = !out_valid || out_ready, so one transfer per cycle is sustained with no bubble.
- Fixed mode: idx = highest set bit of req. For a one-hot req this matches the legacy encoder; for example, bit 7 gives 7.
- Round-robin mode:
  - idx = the first set bit at position ≥ ptr, scanning upward and wrapping modulo N to positions below ptr.
  - ptr is a W-bit internal register holding values 0..N-1.
- Pointer update happens only on accept with mode=1 and req≠0: ptr ← (idx+1) mod N.
  - Wrap from N-1 goes to 0, including when N is not a power of two.
- Pointer hold cases:
  - In fixed mode ptr holds its value; switching modes never clears ptr.
  - On req=0, ptr holds.
- req=0 on accept: none=1, multi=0, idx=0, out_valid=1. An all-zero request is a legal transfer, not a drop.
- multi = popcount(req) ≥ 2, independent of mode.
- Output stall: while out_valid && !out_ready, idx/none/multi/out_valid hold stable and in_ready=0.
- Output drain: if out_ready=1 and no accept occurs that cycle, out_valid ← 0. idx/none/multi keep their last values; they are don't-care for checking but must not be X.

## Timing
- Latency is exactly 1 cycle: accept at edge k, result visible after edge k, out_valid=1 in cycle k+1.
- Throughput is 1 result/cycle when out_ready is held at 1.
- Simultaneous accept and drain in the same cycle: the new result replaces the old one. out_valid stays 1 and ptr updates from the new accept.
- Reset, applied synchronously and dominating every other input including a mid-stall transfer:
  - idx=0, none=0, multi=0, out_valid=0, ptr=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - Any pending result is discarded.
- mode changes take effect on the request accepted in the same cycle; there is no pipeline of mode.

## Structure
- Shared package prio_enc_pkg holds:
  - localparam MODE_FIXED=1'b0 and MODE_RR=1'b1.
  - function rot_next(idx, N), returning (idx+1) mod N.
- One sub-module, find_first_set: a combinational search that takes a vector and a start position and returns the index plus a found flag.
  - Instantiated once for round-robin, with start=ptr.
  - Fixed mode reuses it on the bit-reversed vector with start=0, then maps the index back.
- The top module holds the output register, the skid-free handshake and ptr.

## Test plan
- Fixed mode, N=8, req sweeps one-hot 8'h01..8'h80 back-to-back with out_ready=1 -> idx 0..7, one result per cycle, none=0, multi=0.
- Fixed mode, req=8'b0101_0010 -> idx=6, multi=1.
- Fixed mode, req=0 -> none=1, idx=0, out_valid=1.
- Round-robin, N=8, req=8'hFF held for 10 accepts -> idx 0,1,...,7,0,1, showing wrap at 7->0.
- Round-robin, N=5, ptr=0, req=5'b10001 for three accepts -> idx 0,4,0. Then req=5'b00100 -> idx 2 and ptr becomes 3.
- Stall: accept req=8'h08, hold out_ready=0 for 3 cycles while in_valid=1 with req=8'h40 ->
  - idx=3 is held stable and in_ready=0 throughout.
  - Raise out_ready -> next result idx=6 the following cycle.
- Reset mid-stall: round-robin with ptr=5 and out_valid=1, assert rst for one cycle ->
  - out_valid=0 and in_ready=1.
  - Next request 8'hFF -> idx=0.
